// File: rtl/pc_chan_deser_array_pkg.sv
// pc_chan_pkg: shared types and sizing helpers for the PC config channel
// deserializer array.
//   lane_state_t : per-lane FSM state (IDLE / ACCUM / FULL)
//   nchunks()    : input chunks needed to build one output word
//   chan_w()     : width of a lane index (at least 1 bit)
package pc_chan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FULL  = 2'd2
  } lane_state_t;

  function automatic int nchunks(input int n_out, input int nconf);
    return (n_out + nconf - 1) / nconf;
  endfunction

  function automatic int chan_w(input int nchan);
    return (nchan > 1) ? $clog2(nchan) : 1;
  endfunction

endpackage

// File: rtl/pc_chan_deser_array_if.sv
// pc_chan_deser_array_if: bus bundle between the PC parser lanes, the
// deserializer array and the config consumer.
//   in_d/in_v/in_a            : lane chunk stream (lane i at [i*Nconf +: Nconf])
//   out_d/out_chan/out_v/out_a: merged tagged word stream
//   flush/timeout/err_clr     : per-lane control and shared configuration
//   err_sticky/drop_count     : per-lane timeout-drop status
// master = parser/consumer/config side, slave = deserializer array.
interface pc_chan_deser_array_if #(
  parameter int Nconf     = 16,
  parameter int Nchan     = 4,
  parameter int N_OUT     = 51,
  parameter int N_TIMEOUT = 16,
  parameter int N_DROP    = 8
) ();
  import pc_chan_pkg::*;

  localparam int CW = chan_w(Nchan);

  logic [Nchan*Nconf-1:0]  in_d;
  logic [Nchan-1:0]        in_v;
  logic [Nchan-1:0]        in_a;
  logic [N_OUT-1:0]        out_d;
  logic [CW-1:0]           out_chan;
  logic                    out_v;
  logic                    out_a;
  logic [Nchan-1:0]        flush;
  logic [N_TIMEOUT-1:0]    timeout;
  logic [Nchan-1:0]        err_sticky;
  logic                    err_clr;
  logic [Nchan*N_DROP-1:0] drop_count;

  modport master (
    output in_d, in_v, out_a, flush, timeout, err_clr,
    input  in_a, out_d, out_chan, out_v, err_sticky, drop_count
  );

  modport slave (
    input  in_d, in_v, out_a, flush, timeout, err_clr,
    output in_a, out_d, out_chan, out_v, err_sticky, drop_count
  );

endinterface

// File: rtl/pc_chan_deser_array_lane.sv
// pc_chan_lane: one deserializer lane. Packs Nconf-bit chunks (first chunk in
// the LSBs) into an N_OUT-bit word, holds it until the output takes it, and
// discards stale partial words on idle timeout or flush.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_d/i_v/o_a    : chunk stream
//   i_flush        : discard partial word (ignored while FULL)
//   i_timeout      : idle cycles before a partial word is dropped, 0 = off
//   i_err_clr      : clear sticky error
//   i_take         : held word accepted by the output this cycle
//   o_full/o_word  : word ready / word contents
//   o_err/o_drop   : sticky drop flag / saturating drop count
//
// state | meaning
// IDLE  | no chunks held, cnt = 0
// ACCUM | partial word, 0 < cnt < NCHUNKS
// FULL  | complete word held, waiting for output accept
module pc_chan_lane
  import pc_chan_pkg::*;
#(
  parameter int Nconf     = 16,
  parameter int N_OUT     = 51,
  parameter int N_TIMEOUT = 16,
  parameter int N_DROP    = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [Nconf-1:0]     i_d,
  input  logic                 i_v,
  output logic                 o_a,
  input  logic                 i_flush,
  input  logic [N_TIMEOUT-1:0] i_timeout,
  input  logic                 i_err_clr,
  input  logic                 i_take,
  output logic                 o_full,
  output logic [N_OUT-1:0]     o_word,
  output logic                 o_err,
  output logic [N_DROP-1:0]    o_drop
);

  localparam int NCH  = nchunks(N_OUT, Nconf);
  localparam int CNTW = (NCH > 1) ? $clog2(NCH) : 1;

  lane_state_t          r_state, w_state_nxt;
  logic                 r_run;
  logic [CNTW-1:0]      r_cnt;
  logic [N_OUT-1:0]     r_hold, w_hold_nxt;
  logic [N_TIMEOUT-1:0] r_idle;
  logic                 r_err;
  logic [N_DROP-1:0]    r_drop;
  logic [N_TIMEOUT:0]   w_idle_inc;
  logic                 w_acc, w_last, w_expire, w_clear;

  // in_a stays low during reset and for the first cycle after release.
  assign o_a        = r_run && (r_state != FULL);
  assign w_acc      = i_v && o_a;
  assign w_last     = (r_cnt == CNTW'(NCH - 1));
  assign w_idle_inc = {1'b0, r_idle} + {{N_TIMEOUT{1'b0}}, 1'b1};
  // Expire on the cycle whose edge completes `timeout` idle cycles; an
  // accepted chunk or a flush in that cycle takes priority.
  assign w_expire   = (r_state == ACCUM) && (i_timeout != '0) && !w_acc && !i_flush &&
                      (w_idle_inc >= {1'b0, i_timeout});
  assign w_clear    = (i_flush && (r_state != FULL)) || w_expire;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, ACCUM: begin
        if (i_flush)       w_state_nxt = IDLE;
        else if (w_acc)    w_state_nxt = w_last ? FULL : ACCUM;
        else if (w_expire) w_state_nxt = IDLE;
      end
      FULL:    if (i_take) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Chunk k lands at bits [k*Nconf +: Nconf]; bits beyond N_OUT are dropped.
  always_comb begin
    w_hold_nxt = r_hold;
    for (int b = 0; b < N_OUT; b++) begin
      if ((b / Nconf) == int'(r_cnt)) w_hold_nxt[b] = i_d[b % Nconf];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run  <= 1'b0;
      r_cnt  <= '0;
      r_hold <= '0;
      r_idle <= '0;
      r_err  <= 1'b0;
      r_drop <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_clear)    r_cnt <= '0;
      else if (w_acc) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      if (w_acc && !i_flush) r_hold <= w_hold_nxt;
      if ((r_state != ACCUM) || w_acc) r_idle <= '0;
      else if (r_idle != '1)           r_idle <= r_idle + 1'b1;
      if (w_expire)       r_err <= 1'b1;
      else if (i_err_clr) r_err <= 1'b0;
      if (w_expire && (r_drop != '1)) r_drop <= r_drop + 1'b1;
    end
  end

  assign o_full = (r_state == FULL);
  assign o_word = r_hold;
  assign o_err  = r_err;
  assign o_drop = r_drop;

endmodule

// File: rtl/pc_chan_deser_array.sv
// pc_chan_deser_array: Nchan independent deserializer lanes merged
// round-robin onto one tagged output channel.
//   i_clk   : clock
//   i_reset : asynchronous active-low reset
//   bus     : slave side of pc_chan_deser_array_if (lane streams, merged
//             output, flush/timeout/err_clr, err_sticky/drop_count)
// The grant is registered: a lane that turns FULL at edge t is presented at
// edge t+1. A presented grant is held until out_a; on accept the next FULL
// lane (other than the one just taken) is loaded in the same edge.
module pc_chan_deser_array
  import pc_chan_pkg::*;
#(
  parameter int Nconf     = 16,
  parameter int Nchan     = 4,
  parameter int N_OUT     = 51,
  parameter int N_TIMEOUT = 16,
  parameter int N_DROP    = 8
) (
  input logic                  i_clk,
  input logic                  i_reset,
  pc_chan_deser_array_if.slave bus
);

  localparam int CW = chan_w(Nchan);

  logic [Nchan-1:0]  w_full, w_take, w_in_a, w_err, w_cand;
  logic [N_OUT-1:0]  w_word [Nchan];
  logic [N_DROP-1:0] w_drop [Nchan];
  logic [CW-1:0]     r_ptr, r_gnt, w_nxt, w_start, w_sel;
  logic              r_out_v, w_out_acc, w_found;

  assign w_out_acc = r_out_v && bus.out_a;

  for (genvar gi = 0; gi < Nchan; gi++) begin : g_lane
    pc_chan_lane #(
      .Nconf    (Nconf),
      .N_OUT    (N_OUT),
      .N_TIMEOUT(N_TIMEOUT),
      .N_DROP   (N_DROP)
    ) u_lane (
      .i_clk    (i_clk),
      .i_rst_n  (i_reset),
      .i_d      (bus.in_d[gi*Nconf +: Nconf]),
      .i_v      (bus.in_v[gi]),
      .o_a      (w_in_a[gi]),
      .i_flush  (bus.flush[gi]),
      .i_timeout(bus.timeout),
      .i_err_clr(bus.err_clr),
      .i_take   (w_take[gi]),
      .o_full   (w_full[gi]),
      .o_word   (w_word[gi]),
      .o_err    (w_err[gi]),
      .o_drop   (w_drop[gi])
    );
    assign w_take[gi] = w_out_acc && (r_gnt == CW'(gi));
    assign bus.drop_count[gi*N_DROP +: N_DROP] = w_drop[gi];
  end

  // The lane being taken this edge is still FULL but must not be re-granted.
  assign w_cand  = w_full & ~w_take;
  assign w_nxt   = (r_gnt == CW'(Nchan - 1)) ? '0 : r_gnt + 1'b1;
  assign w_start = w_out_acc ? w_nxt : r_ptr;

  always_comb begin
    w_sel   = w_start;
    w_found = 1'b0;
    for (int k = 0; k < Nchan; k++) begin
      if (!w_found && w_cand[(int'(w_start) + k) % Nchan]) begin
        w_sel   = CW'((int'(w_start) + k) % Nchan);
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_out_v <= 1'b0;
      r_gnt   <= '0;
      r_ptr   <= '0;
    end else begin
      if (!r_out_v || bus.out_a) begin
        r_out_v <= w_found;
        if (w_found) r_gnt <= w_sel;
      end
      if (w_out_acc) r_ptr <= w_start;
    end
  end

  assign bus.out_v      = r_out_v;
  assign bus.out_chan   = r_out_v ? r_gnt : '0;
  assign bus.out_d      = r_out_v ? w_word[r_gnt] : '0;
  assign bus.in_a       = w_in_a;
  assign bus.err_sticky = w_err;

endmodule
